// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake plus decoded payload
// of the RV32I decode stage. The decode stage connects through the slave
// modport; whatever drives instructions in and consumes decoded results uses
// the master modport.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A producer holds valid and payload stable until the transfer.
// Ready never depends combinationally on the partner's valid.
interface decode_stage_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_instruction;
    logic [WIDTH-1:0] i_pc;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_pc;
    logic [6:0]       o_opcode;
    logic [4:0]       o_rd;
    logic [2:0]       o_funct3;
    logic [4:0]       o_rs1;
    logic [4:0]       o_rs2;
    logic [6:0]       o_funct7;
    logic [WIDTH-1:0] o_immediate;
    logic [2:0]       o_format;
    logic             o_illegal;

    modport slave (
        input  i_valid, i_instruction, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_opcode, o_rd, o_funct3, o_rs1,
               o_rs2, o_funct7, o_immediate, o_format, o_illegal
    );

    modport master (
        output i_valid, i_instruction, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_opcode, o_rd, o_funct3, o_rs1,
               o_rs2, o_funct7, o_immediate, o_format, o_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a two-entry skid buffer.
// Each accepted word is split into fields, its sign-extended immediate and
// format are computed, and the result is registered (one cycle latency).
// o_ready is a pure function of the state register so it never depends on
// the downstream ready in the same cycle.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN enables illegal-encoding
// detection on o_illegal; without it o_illegal is tied to 0.
// o_dbg_state exposes the FSM state (0 EMPTY, 1 ONE, 2 FULL).
module decode_stage #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    decode_stage_if.slave        bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [6:0]       funct7;
        logic [WIDTH-1:0] imm;
        logic [2:0]       fmt;
        logic             illegal;
    } dec_t;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    // Reset image: all fields zero, format reads as NONE.
    localparam dec_t DEC_RESET = '{pc: '0, opcode: '0, rd: '0, funct3: '0,
                                   rs1: '0, rs2: '0, funct7: '0, imm: '0,
                                   fmt: FMT_NONE, illegal: 1'b0};

    state_t           state_q, state_d;
    dec_t             out_q, out_d;
    dec_t             skid_q, skid_d;
    dec_t             dec;
    logic [WIDTH-1:0] ins;
    logic             push, pop;

    assign ins  = bus.i_instruction;
    assign push = bus.i_valid && (state_q != ST_FULL);
    assign pop  = (state_q != ST_EMPTY) && bus.i_ready;

    // Combinational decode of the incoming word: fields, format, immediate, illegal flag.
    always_comb begin
        dec        = DEC_RESET;
        dec.pc     = bus.i_pc;
        dec.opcode = ins[6:0];
        dec.rd     = ins[11:7];
        dec.funct3 = ins[14:12];
        dec.rs1    = ins[19:15];
        dec.rs2    = ins[24:20];
        dec.funct7 = ins[31:25];

        case (ins[6:0])
            OPC_LUI, OPC_AUIPC:                       dec.fmt = FMT_U;
            OPC_JAL:                                  dec.fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:                 dec.fmt = FMT_I;
            OPC_BRANCH:                               dec.fmt = FMT_B;
            OPC_STORE:                                dec.fmt = FMT_S;
            OPC_OP:                                   dec.fmt = FMT_R;
            default:                                  dec.fmt = FMT_NONE;
        endcase

        case (dec.fmt)
            FMT_I:   dec.imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   dec.imm = {ins[31:12], 12'b0};
            FMT_J:   dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: dec.imm = '0;
        endcase

`ifdef DECODE_ILLEGAL_CHECK_EN
        // Reserved funct3/funct7 combinations for opcodes that have them;
        // every other opcode is legal unless it has no format at all.
        case (ins[6:0])
            OPC_JALR:   dec.illegal = (ins[14:12] != 3'b000);
            OPC_BRANCH: dec.illegal = (ins[14:12] == 3'b010) || (ins[14:12] == 3'b011);
            OPC_LOAD:   dec.illegal = !((ins[14:12] == 3'b000) || (ins[14:12] == 3'b001) ||
                                        (ins[14:12] == 3'b010) || (ins[14:12] == 3'b100) ||
                                        (ins[14:12] == 3'b101));
            OPC_STORE:  dec.illegal = (ins[14:12] > 3'b010);
            OPC_OP:     dec.illegal = !((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000)) ||
                                      ((ins[31:25] == 7'b0100000) &&
                                       !((ins[14:12] == 3'b000) || (ins[14:12] == 3'b101)));
            OPC_OP_IMM: begin
                if (ins[14:12] == 3'b001) begin
                    dec.illegal = (ins[31:25] != 7'b0000000);
                end else if (ins[14:12] == 3'b101) begin
                    dec.illegal = !((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000));
                end else begin
                    dec.illegal = 1'b0;
                end
            end
            default:    dec.illegal = (dec.fmt == FMT_NONE);
        endcase
`else
        dec.illegal = 1'b0;
`endif
    end

    // Next-state and register loads for the output/skid pair.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    out_d   = dec;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    out_d = dec;
                end else if (push) begin
                    state_d = ST_FULL;
                    skid_d  = dec;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, output and skid registers; reset drops any in-flight entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= DEC_RESET;
            skid_q  <= DEC_RESET;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.o_valid     = (state_q != ST_EMPTY);
    assign bus.o_ready     = (state_q != ST_FULL);
    assign bus.o_pc        = out_q.pc;
    assign bus.o_opcode    = out_q.opcode;
    assign bus.o_rd        = out_q.rd;
    assign bus.o_funct3    = out_q.funct3;
    assign bus.o_rs1       = out_q.rs1;
    assign bus.o_rs2       = out_q.rs2;
    assign bus.o_funct7    = out_q.funct7;
    assign bus.o_immediate = out_q.imm;
    assign bus.o_format    = out_q.fmt;
    assign bus.o_illegal   = out_q.illegal;
    assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed decode vectors with hand-computed expected fields,
// pushed into an expected queue by the driver and checked by a separate
// monitor whenever the stage presents a valid output.
module tb_decode_stage;
    localparam int W  = 32;
    localparam int EW = 100;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    decode_stage_if #(.WIDTH(W)) bus ();

    decode_stage #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk(input logic [31:0] pc, input logic [6:0] op,
                                         input logic [4:0] rd, input logic [2:0] f3,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [6:0] f7, input logic [31:0] imm,
                                         input logic [2:0] fmt, input logic ill);
        return {pc, op, rd, f3, rs1, rs2, f7, imm, fmt, ill};
    endfunction

    function automatic logic [EW-1:0] actual();
        return {bus.o_pc, bus.o_opcode, bus.o_rd, bus.o_funct3, bus.o_rs1, bus.o_rs2,
                bus.o_funct7, bus.o_immediate, bus.o_format, bus.o_illegal};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [EW-1:0] expv);
        logic accepted;
        logic rdy;
        accepted          = 1'b0;
        bus.i_valid       = 1'b1;
        bus.i_instruction = instr;
        bus.i_pc          = pc;
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            rdy = bus.o_ready;
            @(posedge clk);
            if (rdy) begin
                accepted = 1'b1;
                exp_q.push_back(expv);
            end
        end
        #1;
        bus.i_valid = 1'b0;
        if (!accepted) check("push_timeout", EW'(0), EW'(1));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got %h required no output", actual());
            end else if (bus.i_ready) begin
                e = exp_q.pop_front();
                check("decode_out", actual(), e);
            end else begin
                check("stall_hold", actual(), exp_q[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.i_valid       = 1'b0;
        bus.i_instruction = '0;
        bus.i_pc          = '0;
        bus.i_ready       = 1'b1;
        rst_n             = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", EW'(bus.o_valid), EW'(0));
        check("reset_ready", EW'(bus.o_ready), EW'(1));
        check("reset_fields", actual(), mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd7, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed decode vectors, back to back with i_ready=1
        push(32'hFFF10093, 32'h100, mk(32'h100, 7'h13, 5'd1, 3'd0, 5'd2, 5'd31, 7'h7F, 32'hFFFFFFFF, 3'd1, 1'b0));
        push(32'h00532423, 32'h104, mk(32'h104, 7'h23, 5'd8, 3'd2, 5'd6, 5'd5, 7'h00, 32'h00000008, 3'd2, 1'b0));
        push(32'hFE000EE3, 32'h108, mk(32'h108, 7'h63, 5'd29, 3'd0, 5'd0, 5'd0, 7'h7F, 32'hFFFFFFFC, 3'd3, 1'b0));
        push(32'h123451B7, 32'h10C, mk(32'h10C, 7'h37, 5'd3, 3'd5, 5'd8, 5'd3, 7'h09, 32'h12345000, 3'd4, 1'b0));
        push(32'h00000000, 32'h110, mk(32'h110, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, ILL_EN));
        push(32'h40109093, 32'h114, mk(32'h114, 7'h13, 5'd1, 3'd1, 5'd1, 5'd1, 7'h20, 32'h00000401, 3'd1, ILL_EN));
        push(32'h00109093, 32'h118, mk(32'h118, 7'h13, 5'd1, 3'd1, 5'd1, 5'd1, 7'h00, 32'h00000001, 3'd1, 1'b0));
        push(32'h008000EF, 32'h11C, mk(32'h11C, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd8, 7'h00, 32'h00000008, 3'd5, 1'b0));
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: A and B fill the stage, C must wait
        bus.i_ready = 1'b0;
        push(32'h00A00513, 32'h200, mk(32'h200, 7'h13, 5'd10, 3'd0, 5'd0, 5'd10, 7'h00, 32'h0000000A, 3'd1, 1'b0));
        push(32'h008000EF, 32'h204, mk(32'h204, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd8, 7'h00, 32'h00000008, 3'd5, 1'b0));
        check("full_ready", EW'(bus.o_ready), EW'(0));
        check("full_state", EW'(dbg_state), EW'(2));
        bus.i_valid       = 1'b1;
        bus.i_instruction = 32'h40B50533;
        bus.i_pc          = 32'h208;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("c_blocked", EW'(bus.o_ready), EW'(0));
            @(posedge clk);
            #1;
        end
        bus.i_ready = 1'b1;
        push(32'h40B50533, 32'h208, mk(32'h208, 7'h33, 5'd10, 3'd0, 5'd10, 5'd11, 7'h20, 32'h00000000, 3'd0, 1'b0));
        repeat (4) @(posedge clk);
        #1;
        check("drained_bp", EW'(exp_q.size()), EW'(0));

        // Asynchronous reset while FULL drops both entries
        bus.i_ready = 1'b0;
        push(32'hFFF10093, 32'h300, mk(32'h300, 7'h13, 5'd1, 3'd0, 5'd2, 5'd31, 7'h7F, 32'hFFFFFFFF, 3'd1, 1'b0));
        push(32'h123451B7, 32'h304, mk(32'h304, 7'h37, 5'd3, 3'd5, 5'd8, 5'd3, 7'h09, 32'h12345000, 3'd4, 1'b0));
        check("pre_reset_state", EW'(dbg_state), EW'(2));
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_valid", EW'(bus.o_valid), EW'(0));
        check("arst_ready", EW'(bus.o_ready), EW'(1));
        check("arst_fields", actual(), mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd7, 0));
        check("arst_state", EW'(dbg_state), EW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        push(32'h00532423, 32'h400, mk(32'h400, 7'h23, 5'd8, 3'd2, 5'd6, 5'd5, 7'h00, 32'h00000008, 3'd2, 1'b0));

        // Drain with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("final_drain", EW'(exp_q.size()), EW'(0));
        check("final_empty", EW'(bus.o_valid), EW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
